// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan decoder.
// SEG_TABLE is the same active-low glyph table the display encoder uses
// (bit0 = a .. bit6 = g), indexed by the hex nibble it represents.
package seg_pkg;

  localparam int SEG_W = 7;

  // Entry n is the active-low pattern that displays hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // True when exactly one strobe bit is set (zero and multi-hot are rejected).
  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Binary position of the set bit; only meaningful for one-hot input.
  function automatic logic [2:0] onehot8_to_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// seg7_to_hex: inverse of the display glyph table. Purely combinational;
// 'legal' is low for any pattern that no hex digit produces (blank included).
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       legal
);

  // Search the glyph table for an exact match.
  always_comb begin
    nibble = 4'd0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_n == SEG_TABLE[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed seven-segment display bus,
// waits for a digit strobe + segment pattern to hold steady, decodes it to
// hex and offers a change event on a valid/ready port. The last accepted
// value of every digit is kept on 'digits'.
// Build option SEG_DECODE_ERR_EN: when defined, patterns that are not hex
// glyphs are reported as error events (out_err=1, out_nibble=0) instead of
// being dropped silently.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_digit,
  output logic [3:0]              out_nibble,
  output logic                    out_err,
  output logic [4*NUM_DIGITS-1:0] digits
);

  // Input sample, taken every cycle; the FSM only ever looks at this copy.
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   sel_q;

  // Pattern currently being timed in SETTLE and its run length.
  logic [6:0]              pat_seg_q;
  logic [NUM_DIGITS-1:0]   pat_sel_q;
  logic [7:0]              count_q;

  state_t                  state_q;
  logic                    out_valid_q;
  logic [2:0]              out_digit_q;
  logic [3:0]              out_nibble_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic                    err_pending_s;

  logic [7:0]              sel8_s;
  logic                    onehot_s;
  logic [2:0]              idx_s;
  logic [3:0]              dec_nibble_s;
  logic                    dec_legal_s;
  logic [3:0]              cur_digit_s;
  logic                    same_s;
  logic                    count_hit_s;

  seg7_to_hex u_seg7_to_hex (
    .seg_n  (seg_q),
    .nibble (dec_nibble_s),
    .legal  (dec_legal_s)
  );

  // Register the raw bus so every decision works on a single clean sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q <= 7'd0;
      sel_q <= '0;
    end else begin
      seg_q <= seg_n;
      sel_q <= dig_sel;
    end
  end

  // Widen the strobe to 8 bits so the package helpers cover every width.
  always_comb begin
    sel8_s                 = 8'd0;
    sel8_s[NUM_DIGITS-1:0] = sel_q;
  end

  assign onehot_s    = is_onehot8(sel8_s);
  assign idx_s       = onehot8_to_idx(sel8_s);
  assign same_s      = (sel_q == pat_sel_q) && (seg_q == pat_seg_q);
  assign count_hit_s = ((count_q + 8'd1) == 8'(STABLE_CYCLES));

  // Fetch the stored value of the digit being strobed, for duplicate checks.
  always_comb begin
    cur_digit_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_s == 3'(i)) begin
        cur_digit_s = digits_q[4*i +: 4];
      end else begin
      end
    end
  end

`ifdef SEG_DECODE_ERR_EN
  logic out_err_q;
  assign err_pending_s = out_err_q;
`else
  assign err_pending_s = 1'b0;
`endif

  // Main FSM: settle the sample, decode it, then hold the event until taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= 8'd0;
      pat_seg_q    <= 7'd0;
      pat_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      out_digit_q  <= 3'd0;
      out_nibble_q <= 4'd0;
      digits_q     <= '0;
`ifdef SEG_DECODE_ERR_EN
      out_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (onehot_s) begin
            state_q   <= SETTLE;
            count_q   <= 8'd1;
            pat_seg_q <= seg_q;
            pat_sel_q <= sel_q;
          end else begin
            count_q   <= 8'd0;
          end
        end

        SETTLE: begin
          if (!onehot_s) begin
            // Blanking gap or strobe glitch: drop the run.
            state_q <= IDLE;
            count_q <= 8'd0;
          end else if (!same_s) begin
            // A different one-hot sample starts a fresh run.
            count_q   <= 8'd1;
            pat_seg_q <= seg_q;
            pat_sel_q <= sel_q;
          end else if (count_hit_s) begin
            count_q <= 8'd0;
            if (dec_legal_s) begin
              if (dec_nibble_s != cur_digit_s) begin
                state_q      <= EMIT;
                out_valid_q  <= 1'b1;
                out_digit_q  <= idx_s;
                out_nibble_q <= dec_nibble_s;
`ifdef SEG_DECODE_ERR_EN
                out_err_q    <= 1'b0;
`endif
              end else begin
                // Same value already recorded for this digit.
                state_q <= IDLE;
              end
            end else begin
`ifdef SEG_DECODE_ERR_EN
              state_q      <= EMIT;
              out_valid_q  <= 1'b1;
              out_digit_q  <= idx_s;
              out_nibble_q <= 4'd0;
              out_err_q    <= 1'b1;
`else
              state_q      <= IDLE;
`endif
            end
          end else begin
            count_q <= count_q + 8'd1;
          end
        end

        EMIT: begin
          // The bus is ignored here; the event holds until the handshake.
          if (out_valid_q && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            if (!err_pending_s) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (out_digit_q == 3'(i)) begin
                  digits_q[4*i +: 4] <= out_nibble_q;
                end else begin
                end
              end
            end else begin
            end
          end else begin
          end
        end

        default: begin
          state_q     <= IDLE;
          count_q     <= 8'd0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_digit  = out_digit_q;
  assign out_nibble = out_nibble_q;
  assign digits     = digits_q;
`ifdef SEG_DECODE_ERR_EN
  assign out_err    = out_err_q;
`else
  assign out_err    = 1'b0;
`endif

endmodule
